// File: rtl/issue_queue_bank_pkg.sv
// Shared widths, the op2 operand kind and the dispatch/issue entry layout
// used by the issue-queue banks.
package issue_queue_bank_pkg;

    localparam int PHYS_REGS_ADDR_WIDTH = 6;
    localparam int ROB_ADDR_WIDTH       = 5;
    localparam int ALU_CMD_WIDTH        = 4;
    localparam int ISQ_BANK_DEPTH       = 8;
    localparam int ISQ_WB_WIDTH         = 2;

    // REG: op2 holds a physical register tag; IMM: op2 is a literal value.
    typedef enum logic {
        REG = 1'b0,
        IMM = 1'b1
    } op2_type_t;

    typedef struct packed {
        logic [ALU_CMD_WIDTH-1:0]        alu_cmd;
        logic                            op1_valid;
        logic                            op2_valid;
        logic [PHYS_REGS_ADDR_WIDTH-1:0] op1;
        logic [31:0]                     op2;
        op2_type_t                       op2_type;
        logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_rd;
        logic [ROB_ADDR_WIDTH-1:0]       rob_addr;
        logic [31:0]                     pc;
        logic [31:0]                     instr;
        logic                            is_branch_instr;
    } isq_entry_t;

    // An entry may issue once op1 is ready and op2 is ready or an immediate.
    function automatic logic entry_ready(input isq_entry_t e);
        return e.op1_valid && (e.op2_valid || (e.op2_type == IMM));
    endfunction

endpackage

// File: rtl/issue_queue_bank_select.sv
// Oldest-ready picker: the queue is age ordered, so the lowest set bit of
// the ready vector is the oldest ready entry.
module issue_queue_bank_select #(
    parameter int DEPTH = 8,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] ready,
    output logic [DEPTH-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             any_ready
);

    // Scan from the youngest slot down so the lowest ready index wins.
    always_comb begin
        grant     = '0;
        idx       = '0;
        any_ready = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                idx       = IDX_W'(i);
                any_ready = 1'b1;
            end
        end
    end

endmodule

// File: rtl/issue_queue_bank.sv
// One issue-queue bank: a compacting, age-ordered buffer of renamed
// ALU/branch uops that wakes on writeback tags and issues the oldest
// ready entry under a valid/ready handshake.
module issue_queue_bank
    import issue_queue_bank_pkg::*;
#(
    parameter int DEPTH    = ISQ_BANK_DEPTH,
    parameter int WB_WIDTH = ISQ_WB_WIDTH,
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           flush,
    input  logic                                           disp_en,
    output logic                                           disp_full,
    input  isq_entry_t                                     disp_entry,
    input  logic [WB_WIDTH-1:0]                            wb_valid,
    input  logic [WB_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0]  wb_phys_rd,
    output logic                                           issue_valid,
    input  logic                                           issue_ready,
    output isq_entry_t                                     issue_entry,
    output logic [CNT_W-1:0]                               count
);

    localparam int IDX_W = $clog2(DEPTH);

    isq_entry_t       entries_q [DEPTH];
    isq_entry_t       entries_d [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] wr_idx;
    logic [DEPTH-1:0] ready_vec;
    logic [DEPTH-1:0] grant;
    logic [IDX_W-1:0] sel_idx;
    logic             any_ready;
    logic             do_issue;
    logic             do_disp;

    // Set operand-valid bits for any matching writeback tag; p0 never wakes.
    function automatic isq_entry_t wakeup(
        input isq_entry_t                                    e,
        input logic [WB_WIDTH-1:0]                           v,
        input logic [WB_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] tags
    );
        isq_entry_t r;
        r = e;
        for (int k = 0; k < WB_WIDTH; k++) begin
            if (v[k] && (tags[k] != '0)) begin
                if (e.op1 == tags[k]) begin
                    r.op1_valid = 1'b1;
                end
                if ((e.op2_type == REG) && (e.op2 == 32'(tags[k]))) begin
                    r.op2_valid = 1'b1;
                end
            end
        end
        return r;
    endfunction

    assign disp_full   = (count_q == CNT_W'(DEPTH));
    assign count       = count_q;
    assign issue_valid = any_ready;
    assign do_issue    = any_ready && issue_ready;
    assign do_disp     = disp_en && !disp_full;
    // After an issue the queue has compacted by one, so the new slot is one lower.
    assign wr_idx      = count_q - CNT_W'(do_issue);
    assign count_d     = count_q + CNT_W'(do_disp) - CNT_W'(do_issue);

    // Readiness uses only registered operand state, so wakeups count next cycle.
    always_comb begin
        ready_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ready_vec[i] = (CNT_W'(i) < count_q) && entry_ready(entries_q[i]);
        end
    end

    issue_queue_bank_select #(
        .DEPTH (DEPTH)
    ) u_select (
        .ready     (ready_vec),
        .grant     (grant),
        .idx       (sel_idx),
        .any_ready (any_ready)
    );

    // One-hot mux of the selected entry; operands are ready by construction.
    always_comb begin
        issue_entry = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                issue_entry = entries_q[i];
            end
        end
        issue_entry.op1_valid = 1'b1;
        issue_entry.op2_valid = 1'b1;
    end

    // Next storage: wake every slot, compact above an issued slot, append dispatch.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries_d[i] = wakeup(entries_q[i], wb_valid, wb_phys_rd);
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (do_issue && (IDX_W'(i) >= sel_idx)) begin
                entries_d[i] = wakeup(entries_q[i+1], wb_valid, wb_phys_rd);
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (do_disp && (wr_idx == CNT_W'(i))) begin
                entries_d[i] = wakeup(disp_entry, wb_valid, wb_phys_rd);
            end
        end
    end

    // Occupancy register; reset and flush empty the bank and drop this cycle's traffic.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Entry payload register; slots at or above count are don't-care.
    always_ff @(posedge clk) begin
        entries_q <= entries_d;
    end

    a_no_disp_when_full : assert property (
        @(posedge clk) disable iff (rst || flush) !(disp_en && disp_full));

    a_count_in_range : assert property (
        @(posedge clk) disable iff (rst) (count_q <= CNT_W'(DEPTH)));

    a_no_issue_when_empty : assert property (
        @(posedge clk) disable iff (rst) !(do_issue && (count_q == '0)));

endmodule

// File: tb/tb_issue_queue_bank.sv
// Bench for issue_queue_bank: directed vector table, hand-written corner
// sequences and random traffic, all checked against an age-ordered
// queue model of the bank.
module tb_issue_queue_bank;
    import issue_queue_bank_pkg::*;

    localparam int DEPTH = 8;
    localparam int WBW   = 2;
    localparam int PRW   = PHYS_REGS_ADDR_WIDTH;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int NVEC  = 14;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      flush;
    logic                      disp_en;
    logic                      disp_full;
    isq_entry_t                disp_entry;
    logic [WBW-1:0]            wb_valid;
    logic [WBW-1:0][PRW-1:0]   wb_phys_rd;
    logic                      issue_valid;
    logic                      issue_ready;
    isq_entry_t                issue_entry;
    logic [CNT_W-1:0]          count;

    int n_err = 0;
    int n_chk = 0;

    // Reference: oldest entry at the front of the queue.
    isq_entry_t mq[$];

    typedef struct {
        bit         flush;
        bit         disp;
        bit         v1;
        bit         v2;
        logic [PRW-1:0] op1;
        logic [31:0]    op2;
        op2_type_t      t;
        logic [1:0]     wbv;
        logic [PRW-1:0] wb0;
        logic [PRW-1:0] wb1;
        bit         rdy;
        int         exp_count;
        bit         exp_iv;
        logic [PRW-1:0] exp_op1;
        logic [31:0]    exp_op2;
    } vec_t;

    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    issue_queue_bank #(
        .DEPTH    (DEPTH),
        .WB_WIDTH (WBW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .disp_en     (disp_en),
        .disp_full   (disp_full),
        .disp_entry  (disp_entry),
        .wb_valid    (wb_valid),
        .wb_phys_rd  (wb_phys_rd),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_entry (issue_entry),
        .count       (count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_entry(input string name, input isq_entry_t act, input isq_entry_t exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic isq_entry_t mk(input logic [PRW-1:0] op1, input bit v1,
                                      input logic [31:0] op2, input op2_type_t t, input bit v2);
        isq_entry_t e;
        e.alu_cmd         = 4'($urandom);
        e.op1_valid       = v1;
        e.op2_valid       = v2;
        e.op1             = op1;
        e.op2             = op2;
        e.op2_type        = t;
        e.phys_rd         = 6'($urandom);
        e.rob_addr        = 5'($urandom);
        e.pc              = $urandom;
        e.instr           = $urandom;
        e.is_branch_instr = 1'($urandom);
        return e;
    endfunction

    function automatic vec_t v(input bit fl, input bit d, input bit v1, input bit v2,
                               input int op1, input int op2, input op2_type_t t,
                               input int wbv, input int wb0, input int wb1, input bit rdy,
                               input int ec, input bit eiv, input int eop1, input int eop2);
        vec_t r;
        r.flush = fl; r.disp = d; r.v1 = v1; r.v2 = v2;
        r.op1 = PRW'(op1); r.op2 = 32'(op2); r.t = t;
        r.wbv = 2'(wbv); r.wb0 = PRW'(wb0); r.wb1 = PRW'(wb1); r.rdy = rdy;
        r.exp_count = ec; r.exp_iv = eiv; r.exp_op1 = PRW'(eop1); r.exp_op2 = 32'(eop2);
        return r;
    endfunction

    function automatic bit m_ready(input isq_entry_t e);
        return e.op1_valid && (e.op2_type == IMM || e.op2_valid);
    endfunction

    function automatic int m_first_ready();
        foreach (mq[i]) begin
            if (m_ready(mq[i])) return i;
        end
        return -1;
    endfunction

    // A set of tags produced this cycle; any operand naming one becomes ready.
    function automatic isq_entry_t m_wake(input isq_entry_t e, input logic [(1<<PRW)-1:0] live);
        isq_entry_t r;
        r = e;
        if (live[e.op1]) r.op1_valid = 1'b1;
        if (e.op2_type == REG && e.op2 < 32'(1 << PRW) && live[e.op2[PRW-1:0]]) r.op2_valid = 1'b1;
        return r;
    endfunction

    // Advance one clock: update the model with the applied inputs, then compare.
    task automatic tick();
        int sel;
        bit iss;
        bit dsp;
        logic [(1<<PRW)-1:0] live;
        isq_entry_t exp;
        sel  = m_first_ready();
        iss  = !rst && !flush && (sel >= 0) && issue_ready;
        dsp  = !rst && !flush && disp_en && (mq.size() < DEPTH);
        live = '0;
        for (int k = 0; k < WBW; k++) begin
            if (wb_valid[k]) live[wb_phys_rd[k]] = 1'b1;
        end
        live[0] = 1'b0;
        @(posedge clk);
        if (rst || flush) begin
            mq.delete();
        end else begin
            if (iss) mq.delete(sel);
            foreach (mq[i]) mq[i] = m_wake(mq[i], live);
            if (dsp) mq.push_back(m_wake(disp_entry, live));
        end
        #1;
        check("model count", 64'(count), 64'(mq.size()));
        check("model disp_full", 64'(disp_full), 64'(mq.size() == DEPTH));
        sel = m_first_ready();
        check("model issue_valid", 64'(issue_valid), 64'(sel >= 0));
        if (sel >= 0) begin
            exp = mq[sel];
            exp.op1_valid = 1'b1;
            exp.op2_valid = 1'b1;
            check_entry("model issue_entry", issue_entry, exp);
        end
    endtask

    task automatic idle();
        flush       = 1'b0;
        disp_en     = 1'b0;
        wb_valid    = '0;
        wb_phys_rd  = '0;
        issue_ready = 1'b0;
    endtask

    initial begin
        op2_type_t t;
        rst        = 1'b1;
        disp_entry = mk(0, 1'b0, 0, IMM, 1'b0);
        idle();
        tick();
        tick();
        rst = 1'b0;
        check("reset count", 64'(count), 0);
        check("reset issue_valid", 64'(issue_valid), 0);
        check("reset disp_full", 64'(disp_full), 0);

        // flush disp v1 v2 op1 op2 type wbv wb0 wb1 rdy | count iv op1 op2
        vecs[0]  = v(0, 1, 1, 0, 1, 'h10, IMM, 0, 0, 0, 1,  1, 1, 1, 'h10);
        vecs[1]  = v(0, 0, 0, 0, 0, 0,    IMM, 0, 0, 0, 1,  0, 0, 0, 0);
        vecs[2]  = v(0, 1, 0, 0, 5, 'h20, IMM, 0, 0, 0, 1,  1, 0, 0, 0);
        vecs[3]  = v(0, 1, 1, 0, 2, 'h30, IMM, 0, 0, 0, 1,  2, 1, 2, 'h30);
        vecs[4]  = v(0, 0, 0, 0, 0, 0,    IMM, 0, 0, 0, 1,  1, 0, 0, 0);
        vecs[5]  = v(0, 0, 0, 0, 0, 0,    IMM, 1, 5, 0, 1,  1, 1, 5, 'h20);
        vecs[6]  = v(0, 0, 0, 0, 0, 0,    IMM, 0, 0, 0, 1,  0, 0, 0, 0);
        vecs[7]  = v(0, 1, 0, 0, 7, 'h40, IMM, 2, 0, 7, 1,  1, 1, 7, 'h40);
        vecs[8]  = v(0, 0, 0, 0, 0, 0,    IMM, 0, 0, 0, 1,  0, 0, 0, 0);
        vecs[9]  = v(0, 1, 0, 0, 0, 'h50, IMM, 1, 0, 0, 1,  1, 0, 0, 0);
        vecs[10] = v(1, 0, 0, 0, 0, 0,    IMM, 0, 0, 0, 1,  0, 0, 0, 0);
        vecs[11] = v(0, 1, 1, 0, 1, 9,    REG, 0, 0, 0, 1,  1, 0, 0, 0);
        vecs[12] = v(0, 0, 0, 0, 0, 0,    IMM, 2, 0, 9, 1,  1, 1, 1, 9);
        vecs[13] = v(0, 0, 0, 0, 0, 0,    IMM, 0, 0, 0, 1,  0, 0, 0, 0);

        for (int i = 0; i < NVEC; i++) begin
            flush         = vecs[i].flush;
            disp_en       = vecs[i].disp;
            disp_entry    = mk(vecs[i].op1, vecs[i].v1, vecs[i].op2, vecs[i].t, vecs[i].v2);
            wb_valid      = vecs[i].wbv;
            wb_phys_rd[0] = vecs[i].wb0;
            wb_phys_rd[1] = vecs[i].wb1;
            issue_ready   = vecs[i].rdy;
            tick();
            check($sformatf("vec%0d count", i), 64'(count), 64'(vecs[i].exp_count));
            check($sformatf("vec%0d issue_valid", i), 64'(issue_valid), 64'(vecs[i].exp_iv));
            if (vecs[i].exp_iv) begin
                check($sformatf("vec%0d op1", i), 64'(issue_entry.op1), 64'(vecs[i].exp_op1));
                check($sformatf("vec%0d op2", i), 64'(issue_entry.op2), 64'(vecs[i].exp_op2));
            end
        end
        idle();

        // Fill the bank with waiting entries, then wake the one at index 3.
        for (int i = 0; i < DEPTH; i++) begin
            disp_en    = 1'b1;
            disp_entry = mk(PRW'(10 + i), 1'b0, 32'h100 + 32'(i), IMM, 1'b0);
            tick();
        end
        disp_en = 1'b0;
        check("fill count", 64'(count), 8);
        check("fill disp_full", 64'(disp_full), 1);
        check("fill issue_valid", 64'(issue_valid), 0);
        wb_valid      = 2'b01;
        wb_phys_rd[0] = 6'd13;
        issue_ready   = 1'b1;
        tick();
        wb_valid = '0;
        check("fill woken valid", 64'(issue_valid), 1);
        check("fill woken op1", 64'(issue_entry.op1), 13);
        check("fill still full", 64'(disp_full), 1);
        tick();
        check("fill after issue count", 64'(count), 7);
        check("fill after issue disp_full", 64'(disp_full), 0);
        issue_ready   = 1'b0;
        wb_valid      = 2'b01;
        wb_phys_rd[0] = 6'd14;
        tick();
        wb_valid = '0;
        check("fill shifted op1", 64'(issue_entry.op1), 14);
        check("fill shifted op2", 64'(issue_entry.op2), 32'h104);
        flush = 1'b1;
        tick();
        flush = 1'b0;

        // Hold a ready entry while the ALU stalls.
        disp_en    = 1'b1;
        disp_entry = mk(6'd3, 1'b1, 32'h77, IMM, 1'b0);
        tick();
        disp_en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("hold%0d valid", c), 64'(issue_valid), 1);
            check($sformatf("hold%0d op2", c), 64'(issue_entry.op2), 32'h77);
        end
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        check("hold release count", 64'(count), 0);

        // Five entries, simultaneous dispatch and issue, then flush with dispatch.
        for (int i = 0; i < 5; i++) begin
            disp_en    = 1'b1;
            disp_entry = mk(PRW'(20 + i), (i == 0), 32'h200 + 32'(i), IMM, 1'b0);
            tick();
        end
        disp_entry  = mk(6'd30, 1'b0, 32'h300, IMM, 1'b0);
        issue_ready = 1'b1;
        tick();
        check("dual count", 64'(count), 5);
        issue_ready = 1'b0;
        flush       = 1'b1;
        disp_entry  = mk(6'd31, 1'b1, 32'h301, IMM, 1'b0);
        tick();
        check("flush count", 64'(count), 0);
        check("flush issue_valid", 64'(issue_valid), 0);
        flush   = 1'b0;
        disp_en = 1'b0;
        tick();
        check("post flush count", 64'(count), 0);
        check("post flush issue_valid", 64'(issue_valid), 0);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            flush   = ($urandom_range(0, 63) == 0);
            rst     = ($urandom_range(0, 499) == 0);
            disp_en = ($urandom_range(0, 2) != 0) && (mq.size() < DEPTH);
            t       = op2_type_t'($urandom_range(0, 1));
            disp_entry = mk(PRW'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
                            (t == REG) ? 32'($urandom_range(0, 7)) : $urandom,
                            t, ($urandom_range(0, 1) == 1));
            wb_valid      = 2'($urandom);
            wb_phys_rd[0] = PRW'($urandom_range(0, 7));
            wb_phys_rd[1] = PRW'($urandom_range(0, 7));
            issue_ready   = ($urandom_range(0, 3) != 0);
            tick();
        end
        rst = 1'b0;
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
